// File: rtl/ysyx_22041207_lsu.sv
// Load/store unit for the ME stage: freezes the pipeline while a single
// request/response bus transaction is outstanding, aligns store data and masks
// to the 8-byte bus word, and extracts/extends load data from the response.
// Optional build macro YSYX_22041207_LSU_MISALIGN_CHECK_EN: misaligned accesses
// skip the bus and complete with lsu_err=1.
module ysyx_22041207_lsu #(
    parameter int unsigned RESP_WAIT_MAX = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_ren,
    input  logic [7:0]  ex_wmask,
    input  logic [63:0] ex_addr,
    input  logic [63:0] ex_wdata,
    input  logic [3:0]  ex_readNum,
    input  logic        ex_sext,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [63:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [63:0] addr_q, wdata_q, rdata_q, rdata_d;
    logic [7:0]  wmask_q;
    logic        wen_q, sext_q, err_q, err_d;
    logic [2:0]  off_q;
    logic [3:0]  size_q;
    logic [31:0] cnt_q, cnt_d;

    logic        access, is_store, misalign, load_req;
    logic [2:0]  off;
    logic [3:0]  size;
    logic [63:0] shifted, load_data;

    assign access   = ex_valid & (ex_ren | (ex_wmask != 8'h00));
    assign is_store = ex_wmask != 8'h00;
    assign off      = ex_addr[2:0];

    // Normalise the load size; anything other than 1/2/4 is a doubleword
    always_comb begin
        unique case (ex_readNum)
            4'd1, 4'd2, 4'd4: size = ex_readNum;
            default:          size = 4'd8;
        endcase
    end

`ifdef YSYX_22041207_LSU_MISALIGN_CHECK_EN
    logic [3:0] acc_size;

    // Stores take their size from the contiguous byte mask
    always_comb begin
        acc_size = size;
        if (is_store) begin
            unique case (ex_wmask)
                8'h01:   acc_size = 4'd1;
                8'h03:   acc_size = 4'd2;
                8'h0f:   acc_size = 4'd4;
                default: acc_size = 4'd8;
            endcase
        end
        misalign = (({1'b0, off} + acc_size) > 4'd8) |
                   ((off & (acc_size[2:0] - 3'd1)) != 3'd0);
    end
`else
    assign misalign = 1'b0;
`endif

    // Bring the addressed bytes down to bit 0 and extend to 64 bits
    always_comb begin
        shifted = mem_resp_data >> {off_q, 3'b000};
        unique case (size_q)
            4'd1:    load_data = sext_q ? {{56{shifted[7]}}, shifted[7:0]}
                                        : {56'h0, shifted[7:0]};
            4'd2:    load_data = sext_q ? {{48{shifted[15]}}, shifted[15:0]}
                                        : {48'h0, shifted[15:0]};
            4'd4:    load_data = sext_q ? {{32{shifted[31]}}, shifted[31:0]}
                                        : {32'h0, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    // Next-state, timeout counter and result selection
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        load_req      = 1'b0;
        lsu_stall     = 1'b0;
        lsu_done      = 1'b0;
        mem_req_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = 32'd0;
                if (access) begin
                    lsu_stall = 1'b1;
                    if (misalign) begin
                        state_d = StDone;
                        rdata_d = 64'h0;
                        err_d   = 1'b1;
                    end else begin
                        load_req = 1'b1;
                        state_d  = StReq;
                    end
                end
            end
            StReq: begin
                lsu_stall     = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    cnt_d = 32'd0;
                    if (mem_resp_valid) begin
                        state_d = StDone;
                        rdata_d = wen_q ? 64'h0 : load_data;
                        err_d   = 1'b0;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                lsu_stall = 1'b1;
                if (mem_resp_valid) begin
                    state_d = StDone;
                    rdata_d = wen_q ? 64'h0 : load_data;
                    err_d   = 1'b0;
                end else if ((RESP_WAIT_MAX != 0) && ((cnt_q + 32'd1) == RESP_WAIT_MAX)) begin
                    state_d = StDone;
                    rdata_d = 64'h0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDone: begin
                lsu_done = 1'b1;
                state_d  = StIdle;
            end
        endcase
    end

    // State, captured request payload and held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= 64'h0;
            wen_q   <= 1'b0;
            wdata_q <= 64'h0;
            wmask_q <= 8'h00;
            off_q   <= 3'd0;
            size_q  <= 4'd0;
            sext_q  <= 1'b0;
            rdata_q <= 64'h0;
            err_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            if (load_req) begin
                addr_q  <= {ex_addr[63:3], 3'b000};
                wen_q   <= is_store;
                wdata_q <= is_store ? (ex_wdata << {off, 3'b000}) : 64'h0;
                wmask_q <= ex_wmask << off;
                off_q   <= off;
                size_q  <= size;
                sext_q  <= ex_sext;
            end
        end
    end

    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    assign lsu_rdata     = rdata_q;
    assign lsu_err       = (state_q == StDone) & err_q;

endmodule

// File: tb/tb_ysyx_22041207_lsu.sv
// Scoreboard bench for ysyx_22041207_lsu: stimulus pushes expected requests and
// completions; two monitors pop and compare on handshake / lsu_done.
module tb_ysyx_22041207_lsu;

    localparam int unsigned WaitMax = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ren, ex_sext;
    logic [7:0]  ex_wmask;
    logic [63:0] ex_addr, ex_wdata;
    logic [3:0]  ex_readNum;
    logic        lsu_stall, lsu_done, lsu_err;
    logic [63:0] lsu_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;

    ysyx_22041207_lsu #(.RESP_WAIT_MAX(WaitMax)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ren(ex_ren), .ex_wmask(ex_wmask), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_readNum(ex_readNum), .ex_sext(ex_sext),
        .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          issue;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [199:0] act,
                                  input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endfunction

    function automatic req_t mk_req(input logic [63:0] a, input logic w, input logic [63:0] d,
                                    input logic [7:0] m);
        req_t r;
        r.addr  = a;
        r.wen   = w;
        r.wdata = d;
        r.wmask = m;
        return r;
    endfunction

    // Request monitor: payload and stall checked every cycle valid is high
    req_t cur_req;
    always @(negedge clk) begin
        if (rst_n && mem_req_valid) begin
            if (req_q.size() == 0) begin
                check("unexpected_req", 1, 0);
            end else begin
                cur_req = req_q[0];
                check("req_payload",
                      {lsu_stall, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask},
                      {1'b1, cur_req.addr, cur_req.wen, cur_req.wdata, cur_req.wmask});
                if (mem_req_ready) void'(req_q.pop_front());
            end
        end
    end

    // Completion monitor
    rsp_t cur_rsp;
    always @(negedge clk) begin
        if (lsu_done) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                cur_rsp = rsp_q.pop_front();
                check("rsp_rdata", lsu_rdata, cur_rsp.rdata);
                check("rsp_err", lsu_err, cur_rsp.err);
                check("rsp_latency", cyc - cur_rsp.issue, cur_rsp.lat);
                check("rsp_stall", lsu_stall, 0);
            end
        end
    end

    // rsp_wait: -2 response with handshake, -1 never, n>=0 response after n idle WAIT cycles
    task automatic access(input string name, input logic [63:0] addr, input logic ren,
                          input logic [7:0] wm, input logic [63:0] wd, input logic [3:0] num,
                          input logic sx, input int rdy_wait, input int rsp_wait,
                          input logic [63:0] bus_data, input logic bus, input req_t er,
                          input logic [63:0] e_rdata, input logic e_err);
        rsp_t e;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_ren = ren; ex_wmask = wm; ex_wdata = wd;
        ex_addr = addr; ex_readNum = num; ex_sext = sx;
        if (bus) req_q.push_back(er);
        if (!bus)               e.lat = 1;
        else if (rsp_wait == -2) e.lat = 2 + rdy_wait;
        else if (rsp_wait < 0)   e.lat = 2 + rdy_wait + WaitMax;
        else                     e.lat = 3 + rdy_wait + rsp_wait;
        e.rdata = e_rdata;
        e.err   = e_err;
        e.issue = cyc;
        rsp_q.push_back(e);
        #1 check({name, "_stall_idle"}, {lsu_stall, mem_req_valid}, 2'b10);
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_ren = 1'b0; ex_wmask = 8'h00;
        if (bus) begin
            // A response before the handshake must be ignored
            if (rdy_wait > 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            repeat (rdy_wait) begin
                @(posedge clk); #1;
            end
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b1;
            if (rsp_wait == -2) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = bus_data;
            end
            @(posedge clk); #1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (rsp_wait == -1) begin
                repeat (WaitMax) @(posedge clk);
                #1;
            end else if (rsp_wait >= 0) begin
                repeat (rsp_wait) begin
                    check({name, "_wait_stall"}, lsu_stall, 1);
                    @(posedge clk); #1;
                end
                mem_resp_valid = 1'b1;
                mem_resp_data  = bus_data;
                @(posedge clk); #1;
                mem_resp_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        check({name, "_hold"}, {lsu_stall, lsu_rdata}, {1'b0, e_rdata});
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_ren = 1'b0; ex_wmask = 8'h00; ex_addr = 64'h0;
        ex_wdata = 64'h0; ex_readNum = 4'd0; ex_sext = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 64'h0;
        repeat (2) @(posedge clk);
        #1 check("reset_outputs",
                 {mem_req_valid, lsu_stall, lsu_done, lsu_err, lsu_rdata, mem_req_addr,
                  mem_req_wen, mem_req_wdata, mem_req_wmask}, 0);
        #3 rst_n = 1'b1;

        // Valid instruction without a memory access, and a load without valid
        @(posedge clk); #1;
        ex_valid = 1'b1;
        #1 check("no_access_stall", lsu_stall, 0);
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_ren = 1'b1;
        #1 check("ren_no_valid_stall", lsu_stall, 0);
        ex_ren = 1'b0;

        access("ld_w_sext", 64'h8000_0004, 1, 8'h00, 64'h0, 4'd4, 1, 0, -2,
               64'h8000_0001_1234_5678, 1, mk_req(64'h8000_0000, 0, 64'h0, 8'h00),
               64'hFFFF_FFFF_8000_0001, 0);
        access("st_b", 64'h8000_0003, 0, 8'h01, 64'hAB, 4'd1, 0, 0, 0,
               64'hDEAD, 1, mk_req(64'h8000_0000, 1, 64'hAB00_0000, 8'h08), 64'h0, 0);
        access("ld_h_stall", 64'h8000_0010, 1, 8'h00, 64'h0, 4'd2, 0, 5, 1,
               64'h1234_5678_9ABC_F00D, 1, mk_req(64'h8000_0010, 0, 64'h0, 8'h00),
               64'hF00D, 0);
        access("ld_b_sext", 64'h8000_0007, 1, 8'h00, 64'h0, 4'd1, 1, 0, -2,
               64'h8500_0000_0000_0000, 1, mk_req(64'h8000_0000, 0, 64'h0, 8'h00),
               64'hFFFF_FFFF_FFFF_FF85, 0);
        access("ld_h_off2", 64'h8000_0002, 1, 8'h00, 64'h0, 4'd2, 1, 0, 2,
               64'h0000_0000_ABCD_0000, 1, mk_req(64'h8000_0000, 0, 64'h0, 8'h00),
               64'hFFFF_FFFF_FFFF_ABCD, 0);
        access("ld_w_zext", 64'h8000_0004, 1, 8'h00, 64'h0, 4'd4, 0, 0, -2,
               64'h8000_0001_0000_0000, 1, mk_req(64'h8000_0000, 0, 64'h0, 8'h00),
               64'h0000_0000_8000_0001, 0);
`ifdef YSYX_22041207_LSU_MISALIGN_CHECK_EN
        access("mis_ld8", 64'h8000_0004, 1, 8'h00, 64'h0, 4'd8, 0, 0, 0,
               64'h0, 0, mk_req(64'h0, 0, 64'h0, 8'h00), 64'h0, 1);
        access("mis_st4", 64'h8000_0006, 0, 8'h0F, 64'hAABB_CCDD, 4'd1, 0, 0, 0,
               64'h0, 0, mk_req(64'h0, 0, 64'h0, 8'h00), 64'h0, 1);
`else
        access("ovf_ld8", 64'h8000_0004, 1, 8'h00, 64'h0, 4'd8, 0, 0, -2,
               64'h1111_1111_2222_2222, 1, mk_req(64'h8000_0000, 0, 64'h0, 8'h00),
               64'h0000_0000_1111_1111, 0);
        access("ovf_st4", 64'h8000_0006, 0, 8'h0F, 64'hAABB_CCDD, 4'd1, 0, 0, -2,
               64'h0, 1, mk_req(64'h8000_0000, 1, 64'hCCDD_0000_0000_0000, 8'hC0),
               64'h0, 0);
`endif
        access("st_wins", 64'h8000_0004, 1, 8'h0F, 64'h1122_3344, 4'd4, 0, 0, -2,
               64'hFFFF_FFFF_FFFF_FFFF, 1,
               mk_req(64'h8000_0000, 1, 64'h1122_3344_0000_0000, 8'hF0), 64'h0, 0);
        access("ld_sz3", 64'h8000_0008, 1, 8'h00, 64'h0, 4'd3, 1, 0, -2,
               64'hF123_4567_89AB_CDEF, 1, mk_req(64'h8000_0008, 0, 64'h0, 8'h00),
               64'hF123_4567_89AB_CDEF, 0);
        access("timeout", 64'h8000_0020, 1, 8'h00, 64'h0, 4'd8, 0, 0, -1,
               64'h0, 1, mk_req(64'h8000_0020, 0, 64'h0, 8'h00), 64'h0, 1);
        access("ld_d", 64'h8000_0028, 1, 8'h00, 64'h0, 4'd8, 0, 1, 0,
               64'h0123_4567_89AB_CDEF, 1, mk_req(64'h8000_0028, 0, 64'h0, 8'h00),
               64'h0123_4567_89AB_CDEF, 0);

        // Reset pulsed mid-WAIT, then a stray response from the aborted access
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_ren = 1'b1; ex_addr = 64'h8000_0040; ex_readNum = 4'd8;
        req_q.push_back(mk_req(64'h8000_0040, 0, 64'h0, 8'h00));
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_ren = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 check("rst_mid_wait",
                 {mem_req_valid, lsu_stall, lsu_done, lsu_err, lsu_rdata, mem_req_addr,
                  mem_req_wen, mem_req_wdata, mem_req_wmask}, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        mem_resp_valid = 1'b1; mem_resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        check("rst_stray", {lsu_stall, lsu_done, lsu_rdata}, 0);
        mem_resp_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_after", {lsu_stall, lsu_done, mem_req_valid, lsu_rdata}, 0);

        repeat (3) @(posedge clk);
        #1;
        check("req_q_empty", req_q.size(), 0);
        check("rsp_q_empty", rsp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22041207_lsu.md
YSYX_22041207_LSU -- requirements
Module: ysyx_22041207_lsu

Interface
REQ-001 The block SHALL have parameter RESP_WAIT_MAX, default 0, giving the response timeout in cycles, where 0 means no timeout.
REQ-002 The block SHALL have port clk, input, 1 bit: the core clock, all state on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port ex_valid, input, 1 bit: the ME-stage instruction valid.
REQ-005 The block SHALL have port ex_ren, input, 1 bit: the load request.
REQ-006 The block SHALL have port ex_wmask, input, 8 bits: the low-justified store byte mask, where 0 means no store.
REQ-007 The block SHALL have port ex_addr, input, 64 bits: the effective address, taken from the ALU result.
REQ-008 The block SHALL have port ex_wdata, input, 64 bits: the low-justified store data.
REQ-009 The block SHALL have port ex_readNum, input, 4 bits: the load size in bytes, one of 1, 2, 4 or 8.
REQ-010 The block SHALL have port ex_sext, input, 1 bit: selects sign extension (1) or zero extension (0) for loads.
REQ-011 The block SHALL have port lsu_stall, output, 1 bit: the pipeline freeze request.
REQ-012 The block SHALL have port lsu_done, output, 1 bit: a one-cycle completion pulse.
REQ-013 The block SHALL have port lsu_rdata, output, 64 bits: the extended load result.
REQ-014 The block SHALL have port mem_req_valid, output, 1 bit, and port mem_req_ready, input, 1 bit: the request handshake.
REQ-015 The block SHALL have the request-payload outputs mem_req_addr (64 bits), mem_req_wen (1 bit), mem_req_wdata (64 bits) and mem_req_wmask (8 bits).
REQ-016 The block SHALL have the response inputs mem_resp_valid (1 bit) and mem_resp_data (64 bits).
REQ-017 The block SHALL have port lsu_err, output, 1 bit: a misalignment or timeout flag, valid only when lsu_done=1.

Function
REQ-018 The block SHALL implement the states IDLE, REQ, WAIT and DONE.
REQ-019 An access SHALL be defined as ex_valid & (ex_ren | (ex_wmask != 0)); when both ex_ren and a store mask are set, the store wins.
REQ-020 In IDLE with no access, the block SHALL drive lsu_stall=0 and issue no bus activity.
REQ-021 In IDLE with an access, the block SHALL drive lsu_stall=1 combinationally in the same cycle, register the request, and move to REQ.
REQ-022 In REQ the block SHALL hold mem_req_valid=1 with the payload stable until mem_req_ready=1.
REQ-023 On the REQ handshake the block SHALL move to WAIT, or directly to DONE if mem_resp_valid=1 in the same cycle.
REQ-024 In WAIT the block SHALL capture mem_resp_data when mem_resp_valid=1 and move to DONE; stores also wait for a response.
REQ-025 In DONE the block SHALL drive lsu_stall=0 and lsu_done=1 for exactly one cycle, then return to IDLE.
REQ-026 lsu_stall SHALL be 1 in REQ and WAIT.
REQ-027 The minimum access latency SHALL be 3 cycles (IDLE, REQ, DONE).
REQ-028 The request address SHALL be ex_addr with bits [2:0] cleared.
REQ-029 The store path SHALL compute off=ex_addr[2:0], mem_req_wmask=(ex_wmask<<off) truncated to 8 bits, and mem_req_wdata=ex_wdata<<(8*off).
REQ-030 The load path SHALL form mem_resp_data>>(8*off), keep the low ex_readNum bytes, and then sign-extend or zero-extend them to 64 bits per ex_sext.
REQ-031 Any ex_readNum value other than 1, 2 or 4 SHALL be treated as 8.
REQ-032 For stores, lsu_rdata SHALL be 0.
REQ-033 lsu_rdata SHALL hold its value until the next DONE.
REQ-034 When RESP_WAIT_MAX>0 and a counter in WAIT reaches RESP_WAIT_MAX, the block SHALL move to DONE with lsu_err=1 and lsu_rdata=0.
REQ-035 The block SHALL ignore mem_resp_valid in IDLE, REQ (before the handshake) and DONE.

Reset
REQ-036 While rst_n=0, the block SHALL go immediately to IDLE, independent of clk, including mid-REQ or mid-WAIT.
REQ-037 While rst_n=0, the outputs mem_req_valid, lsu_stall, lsu_done and lsu_err SHALL be 0, and lsu_rdata, mem_req_* and the timeout counter SHALL be 0.
REQ-038 After reset, any response still outstanding from before reset SHALL be discarded under REQ-035.

Configuration
REQ-039 With macro YSYX_22041207_LSU_MISALIGN_CHECK_EN defined, an access with off+size>8 or off%size!=0 SHALL skip the bus and go IDLE to DONE, with lsu_err=1, lsu_rdata=0 and no mem_req_valid.
REQ-040 With YSYX_22041207_LSU_MISALIGN_CHECK_EN undefined, such an access SHALL be issued per REQ-029/REQ-030 with the overflowing bytes dropped, and lsu_err SHALL reflect only timeouts.

Verification
REQ-041 The bench SHALL check: load ex_addr=0x8000_0004, ex_readNum=4, ex_sext=1, mem_resp_data=0x8000_0001_xxxx_xxxx with ready and response immediate -> lsu_rdata=0xFFFF_FFFF_8000_0001, lsu_done in cycle 3.
REQ-042 The bench SHALL check: store ex_addr=0x8000_0003, ex_wmask=0x01, ex_wdata=0xAB -> mem_req_addr=0x8000_0000, mem_req_wmask=0x08, mem_req_wdata=0xAB00_0000, mem_req_wen=1.
REQ-043 The bench SHALL check: mem_req_ready held low for 5 cycles -> mem_req_valid and payload stable, lsu_stall=1 throughout.
REQ-044 The bench SHALL check: rst_n pulsed low during WAIT, followed by a stray mem_resp_valid -> IDLE, no lsu_done, lsu_rdata=0.
REQ-045 The bench SHALL check, with the macro defined: load ex_readNum=8, ex_addr=0x8000_0004 -> no request, lsu_err=1 and lsu_done one cycle after IDLE.
REQ-046 The bench SHALL check, with RESP_WAIT_MAX=4: no response -> DONE with lsu_err=1 after 4 WAIT cycles.
